// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared playfield sizes and FSM encodings for the ghost collision block
package game_pkg;
   localparam int T_W   = 16;
   localparam int MAX_X = 640;
   localparam int MAX_Y = 480;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HURT = 2'd2,
      ST_OVER = 2'd3
   } state_t;
endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational trimmed-box overlap test between two sprite tiles
module box_overlap #(
   parameter int T_W        = game_pkg::T_W,
   parameter int HIT_MARGIN = 2
) (
   input  logic [9:0] a_x,
   input  logic [9:0] a_y,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   output logic       overlap
);
   localparam logic [10:0] LO = 11'(HIT_MARGIN);
   localparam logic [10:0] HI = 11'(T_W - HIT_MARGIN);

   logic [10:0] ax, ay, bx, by;
   logic        ov_x, ov_y;

   // One extra bit keeps positions near 1023 from wrapping past the tile edge
   always_comb begin
      ax      = {1'b0, a_x};
      ay      = {1'b0, a_y};
      bx      = {1'b0, b_x};
      by      = {1'b0, b_y};
      ov_x    = ((ax + LO) < (bx + HI)) && ((bx + LO) < (ax + HI));
      ov_y    = ((ay + LO) < (by + HI)) && ((by + LO) < (ay + HI));
      overlap = ov_x && ov_y;
   end
endmodule

// File: rtl/ghost_collision.sv
// rtl/ghost_collision.sv - Yoshi/ghost collision detection with lives and invincibility FSM
module ghost_collision #(
   parameter int T_W        = game_pkg::T_W,
   parameter int HIT_MARGIN = 2,
   parameter int LIVES      = 3,
   parameter int INV_CYCLES = 100000000,
   parameter int FLASH_BIT  = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] y_x,
   input  logic [9:0] y_y,
   input  logic [9:0] g_t_x,
   input  logic [9:0] g_t_y,
   input  logic [9:0] g_b_x,
   input  logic [9:0] g_b_y,
   input  logic [9:0] g_c_x,
   input  logic [9:0] g_c_y,
   output logic       hit,
   output logic [1:0] lives,
   output logic       invincible,
   output logic       yoshi_visible,
   output logic       game_over
);
   import game_pkg::*;

   localparam int               CLOG_W     = $clog2(INV_CYCLES);
   localparam int               TMR_W      = (CLOG_W > FLASH_BIT) ? CLOG_W : FLASH_BIT + 1;
   localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(INV_CYCLES - 1);
   localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_dec;
   logic             ov_t, ov_b, ov_c;
   logic             overlap_reg;

   box_overlap #(.T_W(T_W), .HIT_MARGIN(HIT_MARGIN)) u_ov_t (
      .a_x(y_x), .a_y(y_y), .b_x(g_t_x), .b_y(g_t_y), .overlap(ov_t));
   box_overlap #(.T_W(T_W), .HIT_MARGIN(HIT_MARGIN)) u_ov_b (
      .a_x(y_x), .a_y(y_y), .b_x(g_b_x), .b_y(g_b_y), .overlap(ov_b));
   box_overlap #(.T_W(T_W), .HIT_MARGIN(HIT_MARGIN)) u_ov_c (
      .a_x(y_x), .a_y(y_y), .b_x(g_c_x), .b_y(g_c_y), .overlap(ov_c));

   assign timer_dec = timer - TMR_W'(1);

   // Outputs are registered alongside the state so the blink bit tracks the next timer value
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         lives         <= 2'd0;
         timer         <= '0;
         overlap_reg   <= 1'b0;
         hit           <= 1'b0;
         invincible    <= 1'b0;
         game_over     <= 1'b0;
         yoshi_visible <= 1'b0;
      end else begin
         overlap_reg <= ov_t | ov_b | ov_c;
         hit         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state         <= ST_PLAY;
                  lives         <= LIVES_INIT;
                  yoshi_visible <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (overlap_reg) begin
                  hit <= 1'b1;
                  if (lives > 2'd1) begin
                     state         <= ST_HURT;
                     lives         <= lives - 2'd1;
                     timer         <= TMR_LOAD;
                     invincible    <= 1'b1;
                     yoshi_visible <= TMR_LOAD[FLASH_BIT];
                  end else begin
                     state         <= ST_OVER;
                     lives         <= 2'd0;
                     game_over     <= 1'b1;
                     yoshi_visible <= 1'b1;
                  end
               end
            end
            ST_HURT: begin
               if (timer == '0) begin
                  state         <= ST_PLAY;
                  invincible    <= 1'b0;
                  yoshi_visible <= 1'b1;
               end else begin
                  timer         <= timer_dec;
                  yoshi_visible <= timer_dec[FLASH_BIT];
               end
            end
            ST_OVER: begin
               if (start) begin
                  state         <= ST_PLAY;
                  lives         <= LIVES_INIT;
                  timer         <= '0;
                  game_over     <= 1'b0;
                  yoshi_visible <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ghost_collision.sv
// tb/tb_ghost_collision.sv - self-checking bench for ghost_collision
module tb_ghost_collision;
   localparam int T  = 16;
   localparam int M  = 2;
   localparam int NL = 3;
   localparam int INV = 8;
   localparam int FB = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [9:0] y_x, y_y, g_t_x, g_t_y, g_b_x, g_b_y, g_c_x, g_c_y;
   logic       hit;
   logic [1:0] lives;
   logic       invincible, yoshi_visible, game_over;

   int n_checks = 0;
   int n_fail   = 0;

   ghost_collision #(.T_W(T), .HIT_MARGIN(M), .LIVES(NL), .INV_CYCLES(INV), .FLASH_BIT(FB)) dut (
      .clk(clk), .reset(reset), .start(start),
      .y_x(y_x), .y_y(y_y),
      .g_t_x(g_t_x), .g_t_y(g_t_y),
      .g_b_x(g_b_x), .g_b_y(g_b_y),
      .g_c_x(g_c_x), .g_c_y(g_c_y),
      .hit(hit), .lives(lives), .invincible(invincible),
      .yoshi_visible(yoshi_visible), .game_over(game_over));

   always #5 clk = ~clk;

   typedef struct {
      int yx, yy, tx, ty, bx, by, cx, cy;
      bit exp_hit;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_pos(input int yx, yy, tx, ty, bx, by, cx, cy);
      y_x = 10'(yx);   y_y = 10'(yy);
      g_t_x = 10'(tx); g_t_y = 10'(ty);
      g_b_x = 10'(bx); g_b_y = 10'(by);
      g_c_x = 10'(cx); g_c_y = 10'(cy);
   endtask

   task automatic park();
      set_pos(100, 100, 500, 400, 600, 50, 20, 450);
   endtask

   task automatic new_round();
      park();
      reset = 1'b1; start = 1'b0;
      tick();
      reset = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic bit ref_ov(input int ax, ay, bx, by);
      return (ax + M < bx + T - M) && (bx + M < ax + T - M) &&
             (ay + M < by + T - M) && (by + M < ay + T - M);
   endfunction

   function automatic int near(input int base);
      int v;
      v = base + int'($urandom_range(0, 36)) - 18;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int p[8];
      bit exp_any;
      int next_hit, hits_left, last_hit, exp_lives;
      bit exp_h, exp_inv, exp_vis;

      vecs[0]  = '{100, 100, 111, 100, 600, 50, 20, 450, 1'b1};
      vecs[1]  = '{100, 100, 112, 100, 600, 50, 20, 450, 1'b0};
      vecs[2]  = '{100, 100, 113, 100, 600, 50, 20, 450, 1'b0};
      vecs[3]  = '{100, 100, 89, 100, 600, 50, 20, 450, 1'b1};
      vecs[4]  = '{100, 100, 88, 100, 600, 50, 20, 450, 1'b0};
      vecs[5]  = '{100, 100, 500, 400, 100, 111, 20, 450, 1'b1};
      vecs[6]  = '{100, 100, 500, 400, 600, 50, 100, 112, 1'b0};
      vecs[7]  = '{630, 470, 0, 0, 600, 50, 20, 450, 1'b0};
      vecs[8]  = '{1020, 1020, 500, 400, 600, 50, 0, 0, 1'b0};
      vecs[9]  = '{1020, 1020, 500, 400, 600, 50, 1010, 1010, 1'b1};
      vecs[10] = '{100, 100, 105, 100, 100, 105, 20, 450, 1'b1};
      vecs[11] = '{100, 100, 105, 100, 100, 105, 95, 95, 1'b1};

      // Reset state
      park();
      reset = 1'b1; start = 1'b0;
      tick(); tick();
      check("rst_lives", lives, 0);
      check("rst_hit", hit, 0);
      check("rst_inv", invincible, 0);
      check("rst_over", game_over, 0);
      check("rst_vis", yoshi_visible, 0);

      // Reset outranks start
      start = 1'b1;
      tick();
      check("rst_prio_lives", lives, 0);
      check("rst_prio_vis", yoshi_visible, 0);
      start = 1'b0;

      // Round start, ghosts far
      new_round();
      check("start_lives", lives, NL);
      check("start_vis", yoshi_visible, 1);
      check("start_over", game_over, 0);
      begin
         int hits = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (hit) hits++;
         end
         check("far_no_hit", hits, 0);
      end

      // Table vectors
      for (int v = 0; v < 12; v++) begin
         new_round();
         set_pos(vecs[v].yx, vecs[v].yy, vecs[v].tx, vecs[v].ty,
                 vecs[v].bx, vecs[v].by, vecs[v].cx, vecs[v].cy);
         tick();
         check($sformatf("vec%0d_hit_early", v), hit, 0);
         tick();
         check($sformatf("vec%0d_hit", v), hit, vecs[v].exp_hit);
         check($sformatf("vec%0d_lives", v), lives, vecs[v].exp_hit ? NL - 1 : NL);
         tick();
         check($sformatf("vec%0d_hit_pulse", v), hit, 0);
      end

      // Ghost held overlapping through all lives
      new_round();
      set_pos(100, 100, 111, 100, 600, 50, 20, 450);
      next_hit = 2; hits_left = NL; last_hit = -1000; exp_lives = NL;
      for (int c = 1; c <= 40; c++) begin
         tick();
         exp_h = (c == next_hit) && (hits_left > 0);
         if (exp_h) begin
            hits_left--;
            exp_lives--;
            last_hit = c;
            next_hit = c + INV + 1;
         end
         exp_inv = (exp_lives > 0) && (c - last_hit < INV) && (c >= last_hit);
         exp_vis = exp_inv ? (((INV - 1 - (c - last_hit)) >> FB) & 1) : 1'b1;
         check($sformatf("held_hit_c%0d", c), hit, exp_h);
         check($sformatf("held_lives_c%0d", c), lives, exp_lives);
         check($sformatf("held_inv_c%0d", c), invincible, exp_inv);
         check($sformatf("held_vis_c%0d", c), yoshi_visible, exp_vis);
         check($sformatf("held_over_c%0d", c), game_over, exp_lives == 0);
      end
      park();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_lives", lives, NL);
      check("restart_over", game_over, 0);
      check("restart_vis", yoshi_visible, 1);
      tick(); tick();
      check("restart_no_hit", hit, 0);

      // Start ignored in HURT, then reset mid-HURT with timer at 4
      new_round();
      set_pos(100, 100, 111, 100, 600, 50, 20, 450);
      tick(); tick();
      check("hurt_hit", hit, 1);
      park();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hurt_start_ign_lives", lives, NL - 1);
      check("hurt_start_ign_inv", invincible, 1);
      tick(); tick();
      check("hurt_t4_inv", invincible, 1);
      set_pos(100, 100, 111, 100, 600, 50, 20, 450);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_lives", lives, 0);
      check("midrst_hit", hit, 0);
      check("midrst_inv", invincible, 0);
      check("midrst_over", game_over, 0);
      check("midrst_vis", yoshi_visible, 0);
      tick(); tick(); tick();
      check("idle_no_hit", hit, 0);
      check("idle_lives", lives, 0);
      check("idle_inv", invincible, 0);

      // Randomized positions against the reference model
      for (int r = 0; r < 150; r++) begin
         new_round();
         p[0] = int'($urandom_range(0, 1023));
         p[1] = int'($urandom_range(0, 1023));
         for (int g = 1; g < 4; g++) begin
            if ($urandom_range(0, 1) == 1) begin
               p[2*g]   = near(p[0]);
               p[2*g+1] = near(p[1]);
            end else begin
               p[2*g]   = int'($urandom_range(0, 1023));
               p[2*g+1] = int'($urandom_range(0, 1023));
            end
         end
         exp_any = ref_ov(p[0], p[1], p[2], p[3]) || ref_ov(p[0], p[1], p[4], p[5]) ||
                   ref_ov(p[0], p[1], p[6], p[7]);
         set_pos(p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7]);
         tick(); tick();
         check($sformatf("rnd%0d_hit", r), hit, exp_any);
         check($sformatf("rnd%0d_lives", r), lives, exp_any ? NL - 1 : NL);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
